// File: rtl/exec_stage_alu.sv
// Execute-stage datapath: operand-B select, 32-bit ALU with zero flag and
// PC-step select, all registered once for the memory/writeback/PC stages.
module exec_stage_alu #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PC_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] doa,
  input  logic [XLEN-1:0] dob,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] imm_s,
  input  logic [1:0]      sel_b,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] branch_off,
  input  logic            sel_a,
  output logic [XLEN-1:0] alu_out,
  output logic            zero,
  output logic [XLEN-1:0] pc_step,
  output logic            out_valid
);

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_AND    = 4'b0010,
    OP_OR     = 4'b0011,
    OP_XOR    = 4'b0100,
    OP_SLL    = 4'b0101,
    OP_SRL    = 4'b0110,
    OP_SRA    = 4'b0111,
    OP_SLT    = 4'b1000,
    OP_SLTU   = 4'b1001,
    OP_PASS_B = 4'b1010
  } alu_op_e;

  logic [XLEN-1:0] opb;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_out_d, alu_out_q;
  logic            zero_d, zero_q;
  logic [XLEN-1:0] pc_step_d, pc_step_q;
  logic            out_valid_q;

  always_comb begin
    opb = dob;
    unique case (sel_b)
      2'b00:   opb = imm_i;
      2'b01:   opb = imm_s;
      default: opb = dob;
    endcase
  end

  assign shamt = opb[4:0];

  // Codes 1011..1111 fall through to a zero result, which also forces zero=1.
  always_comb begin
    alu_out_d = '0;
    case (alu_op_e'(alu_ctrl))
      OP_ADD:    alu_out_d = doa + opb;
      OP_SUB:    alu_out_d = doa - opb;
      OP_AND:    alu_out_d = doa & opb;
      OP_OR:     alu_out_d = doa | opb;
      OP_XOR:    alu_out_d = doa ^ opb;
      OP_SLL:    alu_out_d = doa << shamt;
      OP_SRL:    alu_out_d = doa >> shamt;
      OP_SRA:    alu_out_d = $signed(doa) >>> shamt;
      OP_SLT:    alu_out_d = {{(XLEN-1){1'b0}}, ($signed(doa) < $signed(opb))};
      OP_SLTU:   alu_out_d = {{(XLEN-1){1'b0}}, (doa < opb)};
      OP_PASS_B: alu_out_d = opb;
      default:   alu_out_d = '0;
    endcase
  end

  assign zero_d    = (alu_out_d == '0);
  assign pc_step_d = sel_a ? branch_off : XLEN'(PC_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q   <= '0;
      zero_q      <= 1'b0;
      pc_step_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      alu_out_q   <= alu_out_d;
      zero_q      <= zero_d;
      pc_step_q   <= pc_step_d;
      out_valid_q <= in_valid;
    end
  end

  assign alu_out   = alu_out_q;
  assign zero      = zero_q;
  assign pc_step   = pc_step_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_exec_stage_alu.sv
// Bench for exec_stage_alu: directed cases from the datapath rules, then
// random traffic compared against an arithmetic reference model.
module tb_exec_stage_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] doa = '0, dob = '0, imm_i = '0, imm_s = '0, branch_off = '0;
  logic [1:0]  sel_b = '0;
  logic [3:0]  alu_ctrl = '0;
  logic        sel_a = 1'b0;
  logic [31:0] alu_out, pc_step;
  logic        zero, out_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  exec_stage_alu #(.XLEN(32), .PC_STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .doa       (doa),
    .dob       (dob),
    .imm_i     (imm_i),
    .imm_s     (imm_s),
    .sel_b     (sel_b),
    .alu_ctrl  (alu_ctrl),
    .branch_off(branch_off),
    .sel_a     (sel_a),
    .alu_out   (alu_out),
    .zero      (zero),
    .pc_step   (pc_step),
    .out_valid (out_valid)
  );

  function automatic logic [31:0] model_opb(input logic [1:0] sb, input logic [31:0] ii, is, rb);
    if (sb == 2'd0) return ii;
    if (sb == 2'd1) return is;
    return rb;
  endfunction

  // Shifts as multiply/divide by powers of two, compares on widened integers.
  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a, b);
    longint ua, ub, sa, sb, p, r;
    int unsigned sh;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = 32'(b % 32);
    p  = 1;
    for (int unsigned k = 0; k < sh; k++) p = p * 2;
    case (op)
      4'd0:    r = ua + ub;
      4'd1:    r = ua - ub;
      4'd2:    r = {32'd0, a & b};
      4'd3:    r = {32'd0, a | b};
      4'd4:    r = {32'd0, a ^ b};
      4'd5:    r = ua * p;
      4'd6:    r = ua / p;
      4'd7:    r = (sa >= 0) ? sa / p : (sa - (p - 1)) / p;
      4'd8:    r = (sa < sb) ? 1 : 0;
      4'd9:    r = (ua < ub) ? 1 : 0;
      4'd10:   r = ub;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one operation, clock it, then compare the registered outputs.
  task automatic step(input string tag, input logic v, input logic [31:0] a, rb, ii, is,
                      input logic [1:0] sb, input logic [3:0] op,
                      input logic [31:0] off, input logic sa);
    logic [31:0] e_alu, e_pc;
    in_valid = v; doa = a; dob = rb; imm_i = ii; imm_s = is;
    sel_b = sb; alu_ctrl = op; branch_off = off; sel_a = sa;
    e_alu = model_alu(op, a, model_opb(sb, ii, is, rb));
    e_pc  = sa ? off : 32'd4;
    @(posedge clk); #1;
    check({tag, ".alu"},   alu_out,            e_alu);
    check({tag, ".zero"},  {31'd0, zero},      {31'd0, e_alu == 32'd0});
    check({tag, ".pc"},    pc_step,            e_pc);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".alu"},   alu_out,            32'd0);
    check({tag, ".zero"},  {31'd0, zero},      32'd0);
    check({tag, ".pc"},    pc_step,            32'd0);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1; doa = $urandom; dob = $urandom; imm_i = $urandom; imm_s = $urandom;
    sel_b = 2'($urandom); alu_ctrl = 4'($urandom); branch_off = $urandom; sel_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst_n = 1'b1;

    step("first_add", 1'b1, 32'd5, 32'd0, 32'd7, 32'd0, 2'b00, 4'd0, 32'd0, 1'b0);
    check("first_add.const", alu_out, 32'd12);
    step("sub_eq", 1'b1, 32'd10, 32'd10, 32'd3, 32'd3, 2'b10, 4'd1, 32'd0, 1'b0);
    check("sub_eq.zero_const", {31'd0, zero}, 32'd1);
    step("imm_s_add", 1'b0, 32'd10, 32'd0, 32'd0, 32'hFFFF_FFFC, 2'b01, 4'd0, 32'd0, 1'b0);
    check("imm_s_add.const", alu_out, 32'd6);
    step("wrap", 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 2'b00, 4'd0, 32'd0, 1'b0);
    check("wrap.const", alu_out, 32'd0);

    step("srl", 1'b1, 32'h8000_0000, 32'h21, 32'd0, 32'd0, 2'b10, 4'd6, 32'd0, 1'b0);
    check("srl.const", alu_out, 32'h4000_0000);
    step("sra", 1'b1, 32'h8000_0000, 32'h21, 32'd0, 32'd0, 2'b11, 4'd7, 32'd0, 1'b0);
    check("sra.const", alu_out, 32'hC000_0000);
    step("sll", 1'b1, 32'h8000_0000, 32'h21, 32'd0, 32'd0, 2'b10, 4'd5, 32'd0, 1'b0);
    check("sll.const", alu_out, 32'd0);
    step("slt", 1'b1, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 2'b10, 4'd8, 32'd0, 1'b0);
    check("slt.const", alu_out, 32'd1);
    step("sltu", 1'b1, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 2'b10, 4'd9, 32'd0, 1'b0);
    check("sltu.const", alu_out, 32'd0);

    step("pc4", 1'b1, 32'd1, 32'd2, 32'd0, 32'd0, 2'b10, 4'd2, 32'hFFFF_FFF0, 1'b0);
    check("pc4.const", pc_step, 32'd4);
    step("pcbr", 1'b1, 32'd1, 32'd2, 32'd0, 32'd0, 2'b10, 4'd3, 32'hFFFF_FFF0, 1'b1);
    check("pcbr.const", pc_step, 32'hFFFF_FFF0);

    step("bne_cmp", 1'b1, 32'd3, 32'd5, 32'd0, 32'd0, 2'b10, 4'd1, 32'h0000_0040, 1'b0);
    check("bne_cmp.zero_const", {31'd0, zero}, 32'd0);
    check("bne_cmp.pc_const", pc_step, 32'd4);
    step("bne_take", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 2'b10, 4'd0, 32'h0000_0040, 1'b1);
    check("bne_take.pc_const", pc_step, 32'h0000_0040);

    step("pass_b", 1'b1, 32'hDEAD_BEEF, 32'd0, 32'h1234_5000, 32'd0, 2'b00, 4'd10, 32'd0, 1'b0);
    check("pass_b.const", alu_out, 32'h1234_5000);
    step("undef", 1'b1, 32'hDEAD_BEEF, 32'h1, 32'd0, 32'd0, 2'b10, 4'd15, 32'd0, 1'b0);
    check("undef.const", alu_out, 32'd0);
    check("undef.zero_const", {31'd0, zero}, 32'd1);

    step("pre_rst", 1'b1, 32'd100, 32'd23, 32'd0, 32'd0, 2'b10, 4'd0, 32'h80, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("async_rst");
    @(posedge clk); #1;
    check_cleared("rst_hold");
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom), $urandom, $urandom, $urandom, $urandom,
           2'($urandom), 4'($urandom), $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
